// File: rtl/rr_encoder.sv
// rtl/rr_encoder.sv - 4-line round-robin request encoder with sticky pending bits and valid/ready output
module rr_encoder (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic ready,
    output logic valid,
    output logic addr0,
    output logic addr1,
    output logic overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state, state_n;
    logic [3:0] pend, pend_n;
    logic [3:0] req;
    logic [3:0] clr;
    logic [1:0] ptr, ptr_n;
    logic [1:0] addr, addr_n;
    logic [1:0] cand;
    logic [1:0] sel;
    logic       found;
    logic       valid_n;
    logic       overrun_n;

    assign req   = enable ? {in3, in2, in1, in0} : 4'b0000;
    assign addr0 = addr[0];
    assign addr1 = addr[1];

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        addr_n  = addr;
        valid_n = valid;
        clr     = 4'b0000;
        found   = 1'b0;
        sel     = ptr;
        cand    = ptr;
        case (state)
            IDLE: begin
                // Search from the pointer upward, wrapping naturally in 2 bits.
                for (int j = 0; j < 4; j++) begin
                    cand = ptr + 2'(j);
                    if (!found && pend[cand]) begin
                        found = 1'b1;
                        sel   = cand;
                    end
                end
                if (found) begin
                    addr_n  = sel;
                    valid_n = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    clr     = 4'b0001 << addr;
                    valid_n = 1'b0;
                    ptr_n   = addr + 2'd1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // A new request on the bit being cleared wins over the clear.
        pend_n    = (pend & ~clr) | req;
        overrun_n = |(req & pend & ~clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pend    <= 4'b0000;
            ptr     <= 2'd0;
            addr    <= 2'd0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            pend    <= pend_n;
            ptr     <= ptr_n;
            addr    <= addr_n;
            valid   <= valid_n;
            overrun <= overrun_n;
        end
    end

endmodule

// File: doc/rr_encoder.md
RR_ENCODER -- requirements
Module: rr_encoder

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 4 request lines encoded onto 2 address bits.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 enable  input  1  request-capture enable; when 0, in0..in3 SHALL be ignored.
REQ-005 in0, in1, in2, in3  input  1 each  request lines; may be single-cycle pulses or levels.
REQ-006 ready  input  1  consumer accepts the current encoding when ready=1 and valid=1 at a rising edge.
REQ-007 valid  output  1  registered; addr1/addr0 hold a valid encoding.
REQ-008 addr0, addr1  output  1 each  registered encoded index; addr0 is the LSB and addr1 the MSB (index 1 = addr1 0, addr0 1).
REQ-009 overrun  output  1  registered one-cycle pulse flagging a lost duplicate request.

Function
REQ-010 The block SHALL hold a 4-bit sticky pending register pend, a 2-bit round-robin pointer ptr and a two-state FSM {IDLE, HOLD}.
REQ-011 Capture: pend[i] SHALL be set at an edge where enable=1 and in_i=1.
REQ-012 Clear: pend[k] SHALL be cleared at the accepting edge (HOLD, ready=1) for the held index k.
REQ-013 If set and clear of the same bit coincide, set SHALL win; pend[k] stays 1.
REQ-014 IDLE, pend==0: stay IDLE, valid=0.
REQ-015 IDLE, pend!=0: select the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4); load addr1/addr0 with its index; set valid=1; go to HOLD.
REQ-016 Selection SHALL use registered pend only, so latency is 2 edges from a captured request to valid=1.
REQ-017 HOLD, ready=0: addr1, addr0 and valid=1 SHALL remain stable; enable, in0..in3 and pend changes SHALL NOT alter them.
REQ-018 HOLD, ready=1: valid SHALL become 0; ptr SHALL become (held index + 1) mod 4; FSM SHALL return to IDLE.
REQ-019 Minimum spacing between successive valid rising edges SHALL be 2 cycles, i.e. one bubble after each acceptance.
REQ-020 ready while valid=0 SHALL be ignored.
REQ-021 enable=0 SHALL NOT abort an outstanding HOLD; already-pending bits SHALL still be granted.
REQ-022 overrun SHALL be 1 for exactly one cycle after any edge where enable=1, in_i=1, pend[i]=1 and pend[i] is not being cleared at that edge.
REQ-023 overrun SHALL be 0 otherwise; the duplicate request SHALL NOT produce a second grant.
REQ-024 addr1/addr0 SHALL retain their last value when valid=0.

Reset
REQ-025 At an edge with reset=1: pend=0000, ptr=0, FSM=IDLE, valid=0, addr1=0, addr0=0, overrun=0.
REQ-026 reset SHALL dominate all other inputs at the same edge; requests presented on that edge SHALL be discarded.
REQ-027 Reset asserted in HOLD SHALL drop the held encoding without acceptance; ptr SHALL restart at 0.

Verification
REQ-028 Reset, one-cycle in2 pulse with enable=1, ready=0 -> valid=1 at 2nd edge, addr1=1, addr0=0, stable 5 cycles; ready=1 -> valid=0 next edge.
REQ-029 enable=0, in0..in3=1 for 10 cycles -> valid stays 0, overrun stays 0, no grant after enable returns to 1 with inputs low.
REQ-030 After reset, all four inputs pulsed on one edge, ready held 1 -> grants 0,1,2,3 in order, valid rising every 2 cycles.
REQ-031 Grant index 1 (ptr=2), then in0 and in3 pulsed together -> grant 3 first, then 0.
REQ-032 in1 pulsed, then pulsed again while the grant is held with ready=0 -> overrun=1 for one cycle, exactly one grant of index 1.
REQ-033 reset asserted during HOLD with pend=1010 -> valid=0 next edge, no further grants, next in3 request granted with ptr starting at 0.
